// File: rtl/crc_frame_receiver.sv
// rtl/crc_frame_receiver.sv - serial CRC frame receiver: payload capture, CRC residue check
// Optional error counter enabled by defining CRC_RX_ERR_CNT_EN.
module crc_frame_receiver #(
  parameter int               DATA_W  = 11,
  parameter int               CRC_W   = 5,
  parameter logic [CRC_W-1:0] POLY    = 5'b00101,
  parameter logic [CRC_W-1:0] INIT    = '1,
  parameter logic [CRC_W-1:0] RESIDUE = 5'b01100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_bit,
  input  logic              sync,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ok,
  output logic [7:0]        err_cnt
);

  localparam int TOT   = DATA_W + CRC_W;
  localparam int CNT_W = $clog2(TOT + 1);
  localparam logic [CNT_W-1:0] DATA_N = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] TOT_N  = CNT_W'(TOT);

  typedef enum logic [1:0] {IDLE, DATA, CRC, DONE} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt;
  logic [CRC_W-1:0]   crc;
  logic [DATA_W-1:0]  shift;

  logic               fresh;
  logic [CRC_W-1:0]   crc_base, crc_step;
  logic [CNT_W-1:0]   cnt_base, cnt_step;
  logic               fb;

  // A bit arriving outside a frame (or with sync) starts from INIT, not the stale register.
  assign fresh    = sync || (state == IDLE) || (state == DONE);
  assign crc_base = fresh ? INIT : crc;
  assign cnt_base = fresh ? '0 : cnt;
  assign fb       = crc_base[CRC_W-1] ^ in_bit;
  assign crc_step = {crc_base[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  assign cnt_step = cnt_base + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (in_valid) begin
      if (cnt_step == TOT_N)       state_d = DONE;
      else if (cnt_step < DATA_N)  state_d = DATA;
      else                         state_d = CRC;
    end else if (sync || state == DONE) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      crc      <= INIT;
      shift    <= '0;
      out_data <= '0;
    end else if (in_valid) begin
      cnt <= cnt_step;
      crc <= crc_step;
      if (cnt_base < DATA_N) shift <= DATA_W'({shift, in_bit});
      // Payload is complete well before the last CRC bit, so shift is stable here.
      if (state_d == DONE) out_data <= shift;
    end else if (sync) begin
      cnt <= '0;
      crc <= INIT;
    end
  end

  assign busy      = (state == DATA) || (state == CRC);
  assign out_valid = (state == DONE);
  assign out_ok    = (state == DONE) && (crc == RESIDUE);

`ifdef CRC_RX_ERR_CNT_EN
  logic [7:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 8'h00;
    else if (out_valid && !out_ok && err_q != 8'hFF)
      err_q <= err_q + 8'h01;
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_crc_frame_receiver.sv
// tb/tb_crc_frame_receiver.sv - self-checking bench for crc_frame_receiver
module tb_crc_frame_receiver;

`ifdef CRC_RX_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        sync = 1'b0;
  logic        busy;
  logic        out_valid;
  logic [10:0] out_data;
  logic        out_ok;
  logic [7:0]  err_cnt;

  crc_frame_receiver dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .sync(sync),
    .busy(busy), .out_valid(out_valid), .out_data(out_data), .out_ok(out_ok),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int pulses = 0;
  int okp = 0;
  int last_pc = 0;
  int prev_pc = 0;
  int err_exp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      pulses  = pulses + 1;
      if (out_ok) okp = okp + 1;
      prev_pc = last_pc;
      last_pc = cyc;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_err();
    return ERR_EN ? 32'(err_exp) : 32'd0;
  endfunction

  task automatic drive(input logic v, input logic b, input logic s);
    in_valid = v;
    in_bit   = b;
    sync     = s;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] fr, input bit gaps);
    for (int i = 15; i >= 0; i--) begin
      if (gaps) begin
        int g = int'($urandom_range(0, 3));
        repeat (g) drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
      drive(1'b1, fr[i], 1'b0);
      if (i == 15) chk("busy_first_bit", 32'(busy), 32'd1);
    end
  endtask

  typedef struct {
    logic [10:0] payload;
    logic [4:0]  crc;
    bit          gaps;
    bit          exp_ok;
  } vec_t;

  localparam logic [15:0] FR_Z = {11'h000, 5'b01000};
  localparam logic [15:0] FR_A = {11'h7FF, 5'b00010};
  localparam logic [15:0] FR_B = {11'h400, 5'b10111};

  initial begin
    vec_t tab[7];
    int p0;
    int o0;
    logic [15:0] fa;
    logic [15:0] fb;
    tab[0] = '{11'h000, 5'b01000, 1'b0, 1'b1};
    tab[1] = '{11'h000, 5'b01001, 1'b0, 1'b0};
    tab[2] = '{11'h7FF, 5'b00010, 1'b0, 1'b1};
    tab[3] = '{11'h400, 5'b10111, 1'b0, 1'b1};
    tab[4] = '{11'h000, 5'b01000, 1'b1, 1'b1};
    tab[5] = '{11'h400, 5'b10110, 1'b1, 1'b0};
    tab[6] = '{11'h7FF, 5'b00010, 1'b1, 1'b1};
    fa = FR_A;
    fb = FR_B;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_ok", 32'(out_ok), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    #2 rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 7; k++) begin
      p0 = pulses;
      send_frame({tab[k].payload, tab[k].crc}, tab[k].gaps);
      chk($sformatf("vec%0d_out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_out_ok", k), 32'(out_ok), 32'(tab[k].exp_ok));
      chk($sformatf("vec%0d_out_data", k), 32'(out_data), 32'(tab[k].payload));
      if (!tab[k].exp_ok && err_exp < 255) err_exp++;
      drive(1'b0, 1'b1, 1'b0);
      chk($sformatf("vec%0d_pulse_end", k), 32'(out_valid), 32'd0);
      chk($sformatf("vec%0d_pulses", k), 32'(pulses - p0), 32'd1);
      chk($sformatf("vec%0d_data_hold", k), 32'(out_data), 32'(tab[k].payload));
      chk($sformatf("vec%0d_err_cnt", k), 32'(err_cnt), exp_err());
    end

    // 300 back-to-back bad frames saturate the error counter.
    repeat (300) send_frame({11'h000, 5'b01001}, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    err_exp = (err_exp + 300 > 255) ? 255 : err_exp + 300;
    chk("err_saturate", 32'(err_cnt), exp_err());
    send_frame({11'h000, 5'b01001}, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("err_saturate_hold", 32'(err_cnt), exp_err());

    // Sync with a valid bit restarts the frame on that bit.
    p0 = pulses;
    for (int i = 15; i >= 10; i--) drive(1'b1, fa[i], 1'b0);
    chk("sync_pre_outvalid", 32'(pulses - p0), 32'd0);
    drive(1'b1, fb[15], 1'b1);
    chk("sync_busy", 32'(busy), 32'd1);
    for (int i = 14; i >= 0; i--) drive(1'b1, fb[i], 1'b0);
    chk("sync_out_valid", 32'(out_valid), 32'd1);
    chk("sync_out_ok", 32'(out_ok), 32'd1);
    chk("sync_out_data", 32'(out_data), 32'h400);
    drive(1'b0, 1'b0, 1'b0);
    chk("sync_pulses", 32'(pulses - p0), 32'd1);

    // Sync alone drops the partial frame.
    p0 = pulses;
    for (int i = 15; i >= 12; i--) drive(1'b1, fb[i], 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    chk("sync_idle_busy", 32'(busy), 32'd0);
    send_frame(FR_A, 1'b0);
    chk("sync_idle_ok", 32'(out_ok), 32'd1);
    chk("sync_idle_data", 32'(out_data), 32'h7FF);
    drive(1'b0, 1'b0, 1'b0);
    chk("sync_idle_pulses", 32'(pulses - p0), 32'd1);

    // Back-to-back frames, no gap.
    p0 = pulses;
    o0 = okp;
    send_frame(FR_Z, 1'b0);
    send_frame(FR_A, 1'b0);
    chk("b2b_data", 32'(out_data), 32'h7FF);
    drive(1'b0, 1'b0, 1'b0);
    chk("b2b_pulses", 32'(pulses - p0), 32'd2);
    chk("b2b_spacing", 32'(last_pc - prev_pc), 32'd16);
    chk("b2b_ok", 32'(okp - o0), 32'd2);

    // Sync during DONE keeps the completed frame's pulse.
    p0 = pulses;
    send_frame(FR_Z, 1'b0);
    in_valid = 1'b1;
    in_bit   = fb[15];
    sync     = 1'b1;
    #1;
    chk("done_sync_valid", 32'(out_valid), 32'd1);
    chk("done_sync_ok", 32'(out_ok), 32'd1);
    @(posedge clk);
    #1;
    for (int i = 14; i >= 0; i--) drive(1'b1, fb[i], 1'b0);
    chk("done_sync_next_ok", 32'(out_ok), 32'd1);
    chk("done_sync_next_data", 32'(out_data), 32'h400);
    drive(1'b0, 1'b0, 1'b0);
    chk("done_sync_pulses", 32'(pulses - p0), 32'd2);

    // Asynchronous reset mid-frame.
    for (int i = 15; i >= 9; i--) drive(1'b1, fa[i], 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_ok", 32'(out_ok), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_err_cnt", 32'(err_cnt), 32'd0);
    err_exp = 0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    p0 = pulses;
    drive(1'b0, 1'b0, 1'b0);
    send_frame(FR_B, 1'b0);
    chk("post_rst_ok", 32'(out_ok), 32'd1);
    chk("post_rst_data", 32'(out_data), 32'h400);
    drive(1'b0, 1'b0, 1'b0);
    chk("post_rst_pulses", 32'(pulses - p0), 32'd1);
    chk("post_rst_err", 32'(err_cnt), exp_err());

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
